// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with drain-then-halt and MEM timeout
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_re_i,
    input  logic       id_rs2_re_i,
    input  logic       exe_is_load_i,
    input  logic [4:0] exe_rd_i,
    input  logic       exe_busy_i,
    input  logic       jump_i,
    input  logic       mem_req_i,
    input  logic       mem_ack_i,
    input  logic       halt_req_i,
    output logic [5:0] stall_o,
    output logic       flush_o,
    output logic       halt_ack_o,
    output logic       bus_err_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [1:0] drain_cnt;

    logic mem_pending;
    logic lu;
    logic mw;
    logic to;

    // Hazard and wait conditions; a timed-out access counts as done so MEM releases.
    always_comb begin
        mem_pending = mem_req_i && !mem_ack_i;
        lu = exe_is_load_i && (exe_rd_i != 5'd0) &&
             ((id_rs1_re_i && (id_rs1_i == exe_rd_i)) ||
              (id_rs2_re_i && (id_rs2_i == exe_rd_i)));
        mw = mem_pending && (wait_cnt != WAIT_LAST);
        to = mem_pending && (wait_cnt == WAIT_LAST);
    end

    // Priority-encoded stall vector, always contiguous from the pc stage, forced low in reset.
    always_comb begin
        stall_o = 6'b000000;
        if (!rst_i)
            stall_o = 6'b000000;
        else if (state == HALTED)
            stall_o = 6'b111111;
        else if (mw)
            stall_o = 6'b011111;
        else if (exe_busy_i)
            stall_o = 6'b001111;
        else if (jump_i)
            stall_o = 6'b000000;
        else if (lu || (state == DRAIN))
            stall_o = 6'b000111;
        else
            stall_o = 6'b000000;
    end

    // A jump held back by a frozen EXE stage flushes on the first cycle EXE advances.
    assign flush_o = rst_i && jump_i && !stall_o[3] && (state != HALTED);

    // Data-bus wait counter and one-cycle timeout error pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt  <= 8'd0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= to;
            if (mem_pending && !to)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
        end
    end

    // Debug halt sequencer: stop fetch, let EXE/MEM/WB empty, then freeze everything.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= RUN;
            drain_cnt  <= 2'd0;
            halt_ack_o <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    halt_ack_o <= 1'b0;
                    if (halt_req_i && !jump_i) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd0;
                    end
                end
                DRAIN: begin
                    if (!halt_req_i) begin
                        state <= RUN;
                    end else if (!stall_o[3]) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state      <= HALTED;
                            halt_ack_o <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 2'd1;
                        end
                    end
                end
                HALTED: begin
                    if (!halt_req_i) begin
                        state      <= RUN;
                        halt_ack_o <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    halt_ack_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [4:0] id_rs1_i, id_rs2_i, exe_rd_i;
    logic       id_rs1_re_i, id_rs2_re_i, exe_is_load_i, exe_busy_i;
    logic       jump_i, mem_req_i, mem_ack_i, halt_req_i;
    logic [5:0] stall_o;
    logic       flush_o, halt_ack_o, bus_err_o;

    typedef struct {
        string      tag;
        logic [5:0] st;
        logic       fl;
        logic       ak;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_ctrl #(.MEM_TIMEOUT(16), .DRAIN_CYCLES(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_re_i   (id_rs1_re_i),
        .id_rs2_re_i   (id_rs2_re_i),
        .exe_is_load_i (exe_is_load_i),
        .exe_rd_i      (exe_rd_i),
        .exe_busy_i    (exe_busy_i),
        .jump_i        (jump_i),
        .mem_req_i     (mem_req_i),
        .mem_ack_i     (mem_ack_i),
        .halt_req_i    (halt_req_i),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .halt_ack_o    (halt_ack_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        id_rs1_i = 5'd0; id_rs2_i = 5'd0; exe_rd_i = 5'd0;
        id_rs1_re_i = 1'b0; id_rs2_re_i = 1'b0; exe_is_load_i = 1'b0;
        exe_busy_i = 1'b0; jump_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Push the expectation for this cycle, let the logic settle, then pop and compare.
    task automatic chk(input string tag, input logic [5:0] st, input logic fl,
                       input logic ak, input logic er);
        exp_t e;
        e.tag = tag; e.st = st; e.fl = fl; e.ak = ak; e.er = er;
        sb.push_back(e);
        #3;
        e = sb.pop_front();
        n_tests++;
        assert (stall_o === e.st) else begin
            n_fail++; $error("FAIL %s stall_o got %b exp %b", e.tag, stall_o, e.st);
        end
        n_tests++;
        assert (flush_o === e.fl) else begin
            n_fail++; $error("FAIL %s flush_o got %b exp %b", e.tag, flush_o, e.fl);
        end
        n_tests++;
        assert (halt_ack_o === e.ak) else begin
            n_fail++; $error("FAIL %s halt_ack_o got %b exp %b", e.tag, halt_ack_o, e.ak);
        end
        n_tests++;
        assert (bus_err_o === e.er) else begin
            n_fail++; $error("FAIL %s bus_err_o got %b exp %b", e.tag, bus_err_o, e.er);
        end
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic re1, input logic re2);
        exe_is_load_i = 1'b1; exe_rd_i = rd;
        id_rs1_i = rs1; id_rs2_i = rs2; id_rs1_re_i = re1; id_rs2_re_i = re2;
    endtask

    initial begin
        idle();
        halt_req_i = 1'b0;
        rst_i = 1'b0;
        jump_i = 1'b1;
        #2;
        chk("reset_gated", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        idle();
        rst_i = 1'b1;
        chk("after_reset", 6'b000000, 1'b0, 1'b0, 1'b0);

        // load-use: add x6,x5,x1 behind a load of x5
        cyc(); load_use(5'd5, 5'd5, 5'd1, 1'b1, 1'b1);
        chk("lu_rs1", 6'b000111, 1'b0, 1'b0, 1'b0);
        cyc(); idle();
        chk("lu_bubble_done", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        chk("lu_rd_x0", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); load_use(5'd7, 5'd1, 5'd7, 1'b1, 1'b1);
        chk("lu_rs2", 6'b000111, 1'b0, 1'b0, 1'b0);
        cyc(); load_use(5'd7, 5'd1, 5'd7, 1'b1, 1'b0);
        chk("lu_rs2_noread", 6'b000000, 1'b0, 1'b0, 1'b0);

        // memory wait acked after 4 cycles
        for (int i = 0; i < 4; i++) begin
            cyc(); idle(); mem_req_i = 1'b1;
            chk("mw_wait", 6'b011111, 1'b0, 1'b0, 1'b0);
        end
        cyc(); mem_ack_i = 1'b1;
        chk("mw_ack", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); idle();
        chk("mw_no_err", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); mem_req_i = 1'b1; mem_ack_i = 1'b1;
        chk("ack_same_cycle", 6'b000000, 1'b0, 1'b0, 1'b0);

        // timeout: 15 wait cycles, release on the 16th, error pulse on the 17th
        for (int i = 0; i < 15; i++) begin
            cyc(); idle(); mem_req_i = 1'b1;
            chk("to_wait", 6'b011111, 1'b0, 1'b0, 1'b0);
        end
        cyc();
        chk("to_release", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); idle();
        chk("to_err_pulse", 6'b000000, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("to_err_single", 6'b000000, 1'b0, 1'b0, 1'b0);
        // counter restarted at 0: a fresh access again waits a full 15 cycles
        for (int i = 0; i < 15; i++) begin
            cyc(); mem_req_i = 1'b1;
            chk("to_cnt_cleared", 6'b011111, 1'b0, 1'b0, 1'b0);
        end
        cyc(); mem_ack_i = 1'b1;
        chk("to_late_ack", 6'b000000, 1'b0, 1'b0, 1'b0);

        // flush beats load-use
        cyc(); idle(); load_use(5'd5, 5'd5, 5'd1, 1'b1, 1'b1); jump_i = 1'b1;
        chk("jump_lu", 6'b000000, 1'b1, 1'b0, 1'b0);
        // jump deferred by memory wait
        for (int i = 0; i < 2; i++) begin
            cyc(); idle(); jump_i = 1'b1; mem_req_i = 1'b1;
            chk("jump_mw_hold", 6'b011111, 1'b0, 1'b0, 1'b0);
        end
        cyc(); mem_ack_i = 1'b1;
        chk("jump_after_ack", 6'b000000, 1'b1, 1'b0, 1'b0);
        cyc(); idle(); exe_busy_i = 1'b1; jump_i = 1'b1; load_use(5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
        chk("jump_busy_hold", 6'b001111, 1'b0, 1'b0, 1'b0);

        // halt with idle downstream
        cyc(); idle(); halt_req_i = 1'b1;
        chk("halt_req_run", 6'b000000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("drain", 6'b000111, 1'b0, 1'b0, 1'b0);
        end
        cyc();
        chk("halted", 6'b111111, 1'b0, 1'b1, 1'b0);
        cyc(); jump_i = 1'b1;
        chk("halted_no_flush", 6'b111111, 1'b0, 1'b1, 1'b0);
        cyc(); jump_i = 1'b0; halt_req_i = 1'b0;
        chk("halted_drop_req", 6'b111111, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("resume_run", 6'b000000, 1'b0, 1'b0, 1'b0);

        // jump delays entry into drain; drop request mid-drain
        cyc(); halt_req_i = 1'b1; jump_i = 1'b1;
        chk("halt_jump", 6'b000000, 1'b1, 1'b0, 1'b0);
        cyc(); jump_i = 1'b0;
        chk("halt_jump_still_run", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("halt_jump_drain", 6'b000111, 1'b0, 1'b0, 1'b0);
        cyc(); halt_req_i = 1'b0;
        chk("drain_drop_req", 6'b000111, 1'b0, 1'b0, 1'b0);
        cyc();
        chk("drain_abort_run", 6'b000000, 1'b0, 1'b0, 1'b0);

        // memory wait during drain adds one edge
        cyc(); halt_req_i = 1'b1;
        chk("halt2_run", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); mem_req_i = 1'b1;
        chk("drain_mw", 6'b011111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); mem_req_i = 1'b0;
            chk("drain2", 6'b000111, 1'b0, 1'b0, 1'b0);
        end
        cyc();
        chk("halted2", 6'b111111, 1'b0, 1'b1, 1'b0);

        // asynchronous reset while halted
        #2; rst_i = 1'b0;
        chk("rst_halted", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); halt_req_i = 1'b0; rst_i = 1'b1;
        chk("rst_halted_run", 6'b000000, 1'b0, 1'b0, 1'b0);

        // asynchronous reset during a memory wait
        for (int i = 0; i < 5; i++) begin
            cyc(); mem_req_i = 1'b1;
            chk("pre_rst_mw", 6'b011111, 1'b0, 1'b0, 1'b0);
        end
        #2; rst_i = 1'b0;
        chk("rst_mw", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); rst_i = 1'b1;
        chk("rst_mw_release", 6'b011111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            cyc();
            chk("rst_mw_cnt0", 6'b011111, 1'b0, 1'b0, 1'b0);
        end
        cyc();
        chk("rst_mw_timeout", 6'b000000, 1'b0, 1'b0, 1'b0);
        cyc(); idle();
        chk("rst_mw_err", 6'b000000, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
